// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register map and CLAIM field layout shared by the interrupt controller
package irq_ctrl_pkg;
   typedef enum logic [2:0] {
      REG_STATUS = 3'd0,
      REG_MASK   = 3'd1,
      REG_MODE   = 3'd2,
      REG_CLEAR  = 3'd3,
      REG_CLAIM  = 3'd4,
      REG_EOI    = 3'd5,
      REG_INSVC  = 3'd6,
      REG_RSVD   = 3'd7
   } reg_e;
   localparam int CLAIM_VALID_BIT = 31;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder; o_idx is 0 when nothing is set
module irq_prio_enc #(
   parameter int N = 6,
   parameter int W = 3
) (
   input  logic [N-1:0] i_vec,
   output logic         o_valid,
   output logic [W-1:0] o_idx
);
   always_comb begin
      o_valid = |i_vec;
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--) if (i_vec[i]) o_idx = W'(i);
   end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronised, maskable, fixed-priority interrupt controller with in-service nesting
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int N_SRC = 6,
   parameter int ID_W  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       addr,
   input  logic             we,
   input  logic [31:0]      din,
   output logic [31:0]      dout,
   input  logic [N_SRC-1:0] src_irq,
   output logic             int_req
);
   logic [N_SRC-1:0] r_s1, r_s2, r_s3, r_pend, r_mask, r_mode, r_insvc;
   logic             r_int_req;
   logic [N_SRC-1:0] w_wdat, w_edge, w_elig, w_clr, w_mode_chg, w_win_oh, w_eoi_oh, w_pend_nxt;
   logic [ID_W-1:0]  w_win_id, w_is_id;
   logic             w_win_v, w_is_v, w_valid, w_claim, w_unused;
   reg_e             w_reg;

   assign w_reg    = reg_e'(addr);
   assign w_wdat   = din[N_SRC-1:0];
   assign w_unused = ^din[31:N_SRC];
   assign w_edge   = r_s2 & ~r_s3;
   assign w_elig   = r_pend & r_mask;

   irq_prio_enc #(.N(N_SRC), .W(ID_W)) u_win (.i_vec(w_elig),  .o_valid(w_win_v), .o_idx(w_win_id));
   irq_prio_enc #(.N(N_SRC), .W(ID_W)) u_isv (.i_vec(r_insvc), .o_valid(w_is_v),  .o_idx(w_is_id));

   // a winner must outrank every source already in service to preempt
   assign w_valid    = w_win_v && (!w_is_v || w_win_id < w_is_id);
   assign w_claim    = we && w_reg == REG_CLAIM && w_valid;
   assign w_win_oh   = w_claim ? N_SRC'(1) << w_win_id : '0;
   assign w_clr      = (we && w_reg == REG_CLEAR ? w_wdat : '0) | w_win_oh;
   assign w_mode_chg = we && w_reg == REG_MODE ? w_wdat ^ r_mode : '0;
   // ids beyond N_SRC shift out of range and clear nothing
   assign w_eoi_oh   = we && w_reg == REG_EOI ? N_SRC'(1) << din[ID_W-1:0] : '0;
   // an edge event outranks a same-cycle clear; a mode change outranks both
   assign w_pend_nxt = ((r_mode & ((r_pend & ~w_clr) | w_edge)) | (~r_mode & r_s2)) & ~w_mode_chg;
   assign int_req    = r_int_req;

   always_comb begin
      dout = '0;
      case (w_reg)
         REG_STATUS: dout[N_SRC-1:0] = r_pend;
         REG_MASK:   dout[N_SRC-1:0] = r_mask;
         REG_MODE:   dout[N_SRC-1:0] = r_mode;
         REG_CLAIM: begin
            dout[CLAIM_VALID_BIT] = w_valid;
            dout[ID_W-1:0] = w_win_id;
         end
         REG_INSVC:  dout[N_SRC-1:0] = r_insvc;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_s3 <= '0;
         r_pend <= '0;
         r_mask <= '0;
         r_mode <= '0;
         r_insvc <= '0;
         r_int_req <= 1'b0;
      end else begin
         r_s1 <= src_irq;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         r_pend <= w_pend_nxt;
         if (we && w_reg == REG_MASK) r_mask <= w_wdat;
         if (we && w_reg == REG_MODE) r_mode <= w_wdat;
         r_insvc <= (r_insvc | w_win_oh) & ~w_eoi_oh;
         r_int_req <= w_valid;
      end
   end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus a randomized run checked against a register-level model
module tb_irq_ctrl;
   logic        clk, rst, we, int_req;
   logic [2:0]  addr;
   logic [31:0] din, dout, d;
   logic [5:0]  src_irq;
   logic [5:0]  m_pend, m_mask, m_mode, m_insvc, h1, h2, h3;
   logic        m_req;
   int          n_vec = 0, n_err = 0;

   irq_ctrl #(.N_SRC(6), .ID_W(3)) dut (
      .clk(clk), .rst(rst), .addr(addr), .we(we), .din(din),
      .dout(dout), .src_irq(src_irq), .int_req(int_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lowest(input logic [5:0] v);
      for (int i = 0; i < 6; i++) if (v[i]) return i;
      return 6;
   endfunction

   function automatic logic m_valid();
      return lowest(m_pend & m_mask) < lowest(m_insvc);
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] a);
      int w;
      logic [2:0] id;
      w = lowest(m_pend & m_mask);
      id = (w < 6) ? 3'(w) : 3'd0;
      case (a)
         3'd0: return {26'b0, m_pend};
         3'd1: return {26'b0, m_mask};
         3'd2: return {26'b0, m_mode};
         3'd4: return {m_valid(), 28'b0, id};
         3'd6: return {26'b0, m_insvc};
         default: return 32'b0;
      endcase
   endfunction

   task automatic model_clear();
      m_pend = '0; m_mask = '0; m_mode = '0; m_insvc = '0; m_req = 1'b0;
      h1 = '0; h2 = '0; h3 = '0;
   endtask

   // h2/h3 hold src_irq as seen two and three edges ago
   task automatic tick();
      logic [5:0] ev, clr, np, nm, nd, ni;
      int w;
      logic v;
      ev = h2 & ~h3; clr = '0; nm = m_mask; nd = m_mode; ni = m_insvc;
      w = lowest(m_pend & m_mask); v = m_valid();
      if (we) case (addr)
         3'd1: nm = din[5:0];
         3'd2: nd = din[5:0];
         3'd3: clr = din[5:0];
         3'd4: if (v) begin ni[w] = 1'b1; clr[w] = 1'b1; end
         3'd5: if (din[2:0] < 3'd6) ni[din[2:0]] = 1'b0;
         default: ;
      endcase
      for (int i = 0; i < 6; i++)
         np[i] = (nd[i] != m_mode[i]) ? 1'b0 : m_mode[i] ? (ev[i] | (m_pend[i] & ~clr[i])) : h2[i];
      @(posedge clk);
      m_pend = np; m_mask = nm; m_mode = nd; m_insvc = ni; m_req = v;
      h3 = h2; h2 = h1; h1 = src_irq;
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] v);
      addr = a; din = v; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] v);
      addr = a;
      #1;
      v = dout;
   endtask

   task automatic pulse(input int b);
      src_irq[b] = 1'b1;
      tick();
      src_irq[b] = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_level();
      wr(3'd1, 32'h1);
      src_irq[0] = 1'b1;
      repeat (3) tick();
      n_vec++; if (int_req !== 1'b0) begin n_err++; $display("FAIL level_early int_req=%b want 0", int_req); end
      tick();
      n_vec++; if (int_req !== 1'b1) begin n_err++; $display("FAIL level_req int_req=%b want 1", int_req); end
      rd(3'd4, d);
      n_vec++; if (d !== 32'h8000_0000) begin n_err++; $display("FAIL level_claim got %h want 80000000", d); end
      wr(3'd4, 32'h0);
      tick();
      n_vec++; if (int_req !== 1'b0) begin n_err++; $display("FAIL level_claimed int_req=%b want 0", int_req); end
      rd(3'd6, d);
      n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL level_insvc got %h want 1", d); end
      wr(3'd5, 32'h0);
      tick();
      n_vec++; if (int_req !== 1'b1) begin n_err++; $display("FAIL level_reassert int_req=%b want 1", int_req); end
      src_irq[0] = 1'b0;
      repeat (4) tick();
      n_vec++; if (int_req !== 1'b0) begin n_err++; $display("FAIL level_release int_req=%b want 0", int_req); end
   endtask

   task automatic test_edge();
      wr(3'd2, 32'h4);
      wr(3'd1, 32'h4);
      pulse(2);
      rd(3'd0, d);
      n_vec++; if (d !== 32'h4) begin n_err++; $display("FAIL edge_status got %h want 4", d); end
      n_vec++; if (int_req !== 1'b1) begin n_err++; $display("FAIL edge_req int_req=%b want 1", int_req); end
      rd(3'd4, d);
      n_vec++; if (d !== 32'h8000_0002) begin n_err++; $display("FAIL edge_claim got %h want 80000002", d); end
      wr(3'd4, 32'h0);
      rd(3'd0, d);
      n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL edge_status_after got %h want 0", d); end
      rd(3'd6, d);
      n_vec++; if (d !== 32'h4) begin n_err++; $display("FAIL edge_insvc got %h want 4", d); end
      tick();
      n_vec++; if (int_req !== 1'b0) begin n_err++; $display("FAIL edge_drop int_req=%b want 0", int_req); end
      wr(3'd5, 32'h2);
   endtask

   task automatic test_nesting();
      wr(3'd2, 32'h2E);
      wr(3'd1, 32'h3F);
      pulse(3);
      wr(3'd4, 32'h0);
      rd(3'd6, d);
      n_vec++; if (d !== 32'h8) begin n_err++; $display("FAIL nest_insvc got %h want 8", d); end
      pulse(5);
      n_vec++; if (int_req !== 1'b0) begin n_err++; $display("FAIL nest_blocked int_req=%b want 0", int_req); end
      pulse(1);
      n_vec++; if (int_req !== 1'b1) begin n_err++; $display("FAIL nest_preempt int_req=%b want 1", int_req); end
      rd(3'd4, d);
      n_vec++; if (d !== 32'h8000_0001) begin n_err++; $display("FAIL nest_claim1 got %h want 80000001", d); end
      wr(3'd4, 32'h0);
      wr(3'd5, 32'h1);
      wr(3'd5, 32'h3);
      tick();
      n_vec++; if (int_req !== 1'b1) begin n_err++; $display("FAIL nest_after_eoi int_req=%b want 1", int_req); end
      rd(3'd4, d);
      n_vec++; if (d !== 32'h8000_0005) begin n_err++; $display("FAIL nest_claim5 got %h want 80000005", d); end
      wr(3'd4, 32'h0);
      wr(3'd5, 32'h5);
   endtask

   task automatic test_collision();
      src_irq[1] = 1'b1;
      tick();
      src_irq[1] = 1'b0;
      tick();
      wr(3'd3, 32'h2);
      rd(3'd0, d);
      n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL set_wins got %h want 2", d); end
      wr(3'd3, 32'h2);
      rd(3'd0, d);
      n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL clear_after got %h want 0", d); end
   endtask

   task automatic test_mask_illegal();
      pulse(1);
      wr(3'd4, 32'h0);
      pulse(3);
      wr(3'd5, 32'h7);
      wr(3'd7, 32'hFFFF_FFFF);
      rd(3'd6, d);
      n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL illegal_insvc got %h want 2", d); end
      rd(3'd1, d);
      n_vec++; if (d !== 32'h3F) begin n_err++; $display("FAIL illegal_mask got %h want 3f", d); end
      rd(3'd7, d);
      n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reg7_read got %h want 0", d); end
      wr(3'd5, 32'h1);
      tick();
      n_vec++; if (int_req !== 1'b1) begin n_err++; $display("FAIL unblock int_req=%b want 1", int_req); end
      wr(3'd1, 32'h0);
      tick();
      n_vec++; if (int_req !== 1'b0) begin n_err++; $display("FAIL masked int_req=%b want 0", int_req); end
      rd(3'd4, d);
      n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL masked_claim got %h want 0", d); end
      pulse(2);
      rd(3'd0, d);
      n_vec++; if (d !== 32'hC) begin n_err++; $display("FAIL pend_pre_toggle got %h want c", d); end
      wr(3'd2, 32'h2A);
      rd(3'd0, d);
      n_vec++; if (d !== 32'h8) begin n_err++; $display("FAIL mode_toggle got %h want 8", d); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(3) == 0) src_irq = 6'($urandom);
         addr = 3'($urandom);
         din = (addr == 3'd5) ? 32'($urandom_range(7)) : $urandom;
         we = ($urandom_range(2) == 0);
         if (addr == 3'd2 && $urandom_range(3) != 0) we = 1'b0;
         #1;
         n_vec++; if (dout !== m_read(addr)) begin n_err++; $display("FAIL rand_read[%0d] addr=%0d got %h want %h", n, addr, dout, m_read(addr)); end
         tick();
         we = 1'b0;
         n_vec++; if (int_req !== m_req) begin n_err++; $display("FAIL rand_req[%0d] int_req=%b want %b", n, int_req, m_req); end
      end
   endtask

   task automatic test_reset();
      #2;
      rst = 1'b0; we = 1'b0; src_irq = '0; addr = 3'd0;
      #1;
      model_clear();
      n_vec++; if (int_req !== 1'b0) begin n_err++; $display("FAIL rst_req int_req=%b want 0", int_req); end
      n_vec++; if (dout !== 32'h0) begin n_err++; $display("FAIL rst_status got %h want 0", dout); end
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), d);
         n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_reg%0d got %h want 0", a, d); end
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (2) tick();
      n_vec++; if (int_req !== m_req) begin n_err++; $display("FAIL rst_release int_req=%b want %b", int_req, m_req); end
   endtask

   initial begin
      rst = 1'b0; we = 1'b0; addr = '0; din = '0; src_irq = '0;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      test_level();
      test_edge();
      test_nesting();
      test_collision();
      test_mask_illegal();
      test_random();
      test_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
